// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
//
// Session sequencer that owns the CPU external memory ports and the CPU
// enable pin. One session runs as follows:
//   1. Stream a program image from the host into instruction memory.
//   2. Stream an initial image from the host into data memory.
//   3. Run the CPU until it halts or the cycle budget runs out.
//   4. Keep the CPU enabled for DRAIN_CYC more cycles so that in-flight
//      instructions retire.
//   5. Read back a data-memory window and stream it out to the host.
//
// Optional build macro: RUN_CTRL_CHECKSUM_EN
//   When defined, one extra output beat follows the dump. It carries the
//   32-bit wrapping sum of all dumped words. The sum is 0 when no words are
//   dumped.
//
// Parameters:
//   ADDR_W    : width of the external byte-address buses (word stride 4)
//   CNT_W     : width of the word counts and of the cycle budget
//   DRAIN_CYC : number of post-halt cycles the CPU stays enabled (>= 1)
//
// Ports:
//   i_clk, i_srst        : clock and synchronous active-high reset
//   i_start              : pulse that begins a session (ignored while busy)
//   i_imem_words         : number of words to load into instruction memory
//   i_dmem_words         : number of words to load into data memory
//   i_cyc_budget         : maximum number of RUN cycles (0 = unlimited)
//   i_dump_base          : byte address of the readback window
//   i_dump_words         : number of words to read back
//   i_halt               : CPU halt indication, sampled in RUN only
//   i_in_valid/i_in_data : host load stream
//   o_in_ready           : load-stream ready
//   o_out_valid/o_out_data, i_out_ready : host readback stream
//   o_cpu_enable         : drives the CPU enable pin
//   o_addr_ext, o_wen_ext, o_ren_ext, o_wdata_ext : instruction-memory port
//   o_addr_ext_2, o_wen_ext_2, o_ren_ext_2, o_wdata_ext_2, i_rdata_ext_2 :
//       data-memory port; read data is valid 1 cycle after o_ren_ext_2
//   o_busy               : high in every state except IDLE and DONE
//   o_done               : high in DONE
//   o_timeout            : in DONE, high when the budget (not halt) ended RUN
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 4
) (
    input  logic              i_clk,
    input  logic              i_srst,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_imem_words,
    input  logic [CNT_W-1:0]  i_dmem_words,
    input  logic [CNT_W-1:0]  i_cyc_budget,
    input  logic [ADDR_W-1:0] i_dump_base,
    input  logic [CNT_W-1:0]  i_dump_words,
    input  logic              i_halt,
    input  logic              i_in_valid,
    input  logic [31:0]       i_in_data,
    output logic              o_in_ready,
    output logic              o_out_valid,
    output logic [31:0]       o_out_data,
    input  logic              i_out_ready,
    output logic              o_cpu_enable,
    output logic [ADDR_W-1:0] o_addr_ext,
    output logic              o_wen_ext,
    output logic              o_ren_ext,
    output logic [31:0]       o_wdata_ext,
    output logic [ADDR_W-1:0] o_addr_ext_2,
    output logic              o_wen_ext_2,
    output logic              o_ren_ext_2,
    output logic [31:0]       o_wdata_ext_2,
    input  logic [31:0]       i_rdata_ext_2,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_timeout
);

    localparam int DRW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_I,
        S_LOAD_D,
        S_RUN,
        S_DRAIN,
        S_DUMP_RD,
        S_DUMP_WAIT,
        S_DUMP_OUT,
        S_SUM_OUT,
        S_DONE
    } state_t;

    state_t              r_state;

    // Session parameters, latched on start.
    logic [CNT_W-1:0]    r_imem_words;
    logic [CNT_W-1:0]    r_dmem_words;
    logic [CNT_W-1:0]    r_budget;
    logic [ADDR_W-1:0]   r_dump_base;
    logic [CNT_W-1:0]    r_dump_words;

    // Progress counters.
    logic [CNT_W-1:0]    r_k;        // load word index
    logic [CNT_W-1:0]    r_j;        // dump word index
    logic [CNT_W-1:0]    r_cyc;      // RUN cycles completed
    logic [DRW-1:0]      r_drain;    // DRAIN cycles completed

    // Registered outputs.
    logic [ADDR_W-1:0]   r_addr_i;
    logic [ADDR_W-1:0]   r_addr_d;   // shared by data load and dump readback
    logic                r_in_ready;
    logic                r_cpu_enable;
    logic                r_ren_d;
    logic                r_out_valid;
    logic [31:0]         r_out_data;
    logic                r_busy;
    logic                r_done;
    logic                r_timeout;

`ifdef RUN_CTRL_CHECKSUM_EN
    logic [31:0]         r_sum;
`endif

    // The write strobes have to fire in the handshake cycle itself, so they
    // are decoded from the state register and the host valid.
    logic                w_hs_i;
    logic                w_hs_d;

    assign w_hs_i = (r_state == S_LOAD_I) && i_in_valid;
    assign w_hs_d = (r_state == S_LOAD_D) && i_in_valid;

    assign o_in_ready    = r_in_ready;
    assign o_cpu_enable  = r_cpu_enable;
    assign o_addr_ext    = r_addr_i;
    assign o_wen_ext     = w_hs_i;
    assign o_ren_ext     = 1'b0;
    assign o_wdata_ext   = w_hs_i ? i_in_data : 32'd0;
    assign o_addr_ext_2  = r_addr_d;
    assign o_wen_ext_2   = w_hs_d;
    assign o_ren_ext_2   = r_ren_d;
    assign o_wdata_ext_2 = w_hs_d ? i_in_data : 32'd0;
    assign o_out_valid   = r_out_valid;
    assign o_out_data    = r_out_data;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_timeout     = r_timeout;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_state      <= S_IDLE;
            r_imem_words <= '0;
            r_dmem_words <= '0;
            r_budget     <= '0;
            r_dump_base  <= '0;
            r_dump_words <= '0;
            r_k          <= '0;
            r_j          <= '0;
            r_cyc        <= '0;
            r_drain      <= '0;
            r_addr_i     <= '0;
            r_addr_d     <= '0;
            r_in_ready   <= 1'b0;
            r_cpu_enable <= 1'b0;
            r_ren_d      <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= 32'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
`ifdef RUN_CTRL_CHECKSUM_EN
            r_sum        <= 32'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_imem_words <= i_imem_words;
                        r_dmem_words <= i_dmem_words;
                        r_budget     <= i_cyc_budget;
                        r_dump_base  <= i_dump_base;
                        r_dump_words <= i_dump_words;
                        r_k          <= '0;
                        r_j          <= '0;
                        r_cyc        <= '0;
                        r_drain      <= '0;
                        r_addr_i     <= '0;
                        r_addr_d     <= '0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_timeout    <= 1'b0;
`ifdef RUN_CTRL_CHECKSUM_EN
                        r_sum        <= 32'd0;
`endif
                        if (i_imem_words != '0) begin
                            r_state    <= S_LOAD_I;
                            r_in_ready <= 1'b1;
                        end else if (i_dmem_words != '0) begin
                            r_state    <= S_LOAD_D;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state      <= S_RUN;
                            r_cpu_enable <= 1'b1;
                        end
                    end
                end

                S_LOAD_I: begin
                    if (w_hs_i) begin
                        r_addr_i <= r_addr_i + ADDR_W'(4);
                        r_k      <= r_k + CNT_W'(1);
                        // Compare against count-1 so that a full-range count
                        // completes without the index wrapping.
                        if (r_k == r_imem_words - CNT_W'(1)) begin
                            r_k <= '0;
                            if (r_dmem_words != '0) begin
                                r_state <= S_LOAD_D;
                            end else begin
                                r_state      <= S_RUN;
                                r_in_ready   <= 1'b0;
                                r_cpu_enable <= 1'b1;
                            end
                        end
                    end
                end

                S_LOAD_D: begin
                    if (w_hs_d) begin
                        r_addr_d <= r_addr_d + ADDR_W'(4);
                        r_k      <= r_k + CNT_W'(1);
                        if (r_k == r_dmem_words - CNT_W'(1)) begin
                            r_k          <= '0;
                            r_state      <= S_RUN;
                            r_in_ready   <= 1'b0;
                            r_cpu_enable <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    r_cyc <= r_cyc + CNT_W'(1);
                    // Halt is checked first so that it wins a tie with the
                    // budget and leaves timeout clear.
                    if (i_halt) begin
                        r_state <= S_DRAIN;
                    end else if ((r_budget != '0) &&
                                 (r_cyc == r_budget - CNT_W'(1))) begin
                        r_state   <= S_DRAIN;
                        r_timeout <= 1'b1;
                    end
                end

                S_DRAIN: begin
                    if (r_drain == DRW'(DRAIN_CYC - 1)) begin
                        r_cpu_enable <= 1'b0;
                        r_addr_d     <= r_dump_base;
                        if (r_dump_words != '0) begin
                            r_state <= S_DUMP_RD;
                            r_ren_d <= 1'b1;
                        end else begin
`ifdef RUN_CTRL_CHECKSUM_EN
                            // Empty window: the checksum beat carries 0.
                            r_state     <= S_SUM_OUT;
                            r_out_data  <= 32'd0;
                            r_out_valid <= 1'b1;
`else
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
`endif
                        end
                    end else begin
                        r_drain <= r_drain + DRW'(1);
                    end
                end

                S_DUMP_RD: begin
                    r_ren_d <= 1'b0;
                    r_state <= S_DUMP_WAIT;
                end

                S_DUMP_WAIT: begin
                    r_out_data  <= i_rdata_ext_2;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DUMP_OUT;
                end

                S_DUMP_OUT: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_j         <= r_j + CNT_W'(1);
                        r_addr_d    <= r_addr_d + ADDR_W'(4);
`ifdef RUN_CTRL_CHECKSUM_EN
                        r_sum       <= r_sum + r_out_data;
`endif
                        if (r_j == r_dump_words - CNT_W'(1)) begin
`ifdef RUN_CTRL_CHECKSUM_EN
                            r_state     <= S_SUM_OUT;
                            r_out_data  <= r_sum + r_out_data;
                            r_out_valid <= 1'b1;
`else
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
`endif
                        end else begin
                            r_state <= S_DUMP_RD;
                            r_ren_d <= 1'b1;
                        end
                    end
                end

`ifdef RUN_CTRL_CHECKSUM_EN
                S_SUM_OUT: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
`endif

                default: begin
                    r_state      <= S_IDLE;
                    r_in_ready   <= 1'b0;
                    r_cpu_enable <= 1'b0;
                    r_ren_d      <= 1'b0;
                    r_out_valid  <= 1'b0;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

endmodule
